// File: rtl/serializer_rr_scheduler.sv
// Round-robin scheduler that shares one W-bit parallel-to-serial shifter among N requesters.
// Each grant loads one word, then blocks further grants for W shift cycles plus GAP idle cycles.
module serializer_rr_scheduler #(
  parameter int N   = 4,
  parameter int W   = 6,
  parameter int GAP = 1,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N*W-1:0]    data_in,
  output logic [N-1:0]      ack,
  output logic              ser_load,
  output logic [W-1:0]      ser_data,
  output logic              ser_active,
  output logic [IW-1:0]     grant_id,
  output logic              done
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    gcnt;
  logic [IW-1:0] last;
  logic [IW-1:0] winner;
  logic [IW-1:0] cand;
  logic          any;
  int unsigned   idx;

  // Scan last+1, last+2, ... (mod N); the first requesting index wins.
  always_comb begin
    winner = last;
    any    = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx  = (32'(last) + k) % N;
      cand = IW'(idx);
      if (!any && req[cand]) begin
        any    = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      gcnt       <= '0;
      last       <= IW'(N - 1);
      ack        <= '0;
      ser_load   <= 1'b0;
      ser_data   <= '0;
      ser_active <= 1'b0;
      grant_id   <= '0;
      done       <= 1'b0;
    end else begin
      ser_load <= 1'b0;
      ack      <= '0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any) begin
            state    <= S_LOAD;
            grant_id <= winner;
            last     <= winner;
            ser_data <= data_in[32'(winner)*W +: W];
            ser_load <= 1'b1;
            ack      <= N'(1) << winner;
          end
        end
        S_LOAD: begin
          state      <= S_SHIFT;
          cnt        <= CNT_LAST;
          ser_active <= 1'b1;
        end
        S_SHIFT: begin
          // done is registered, so it is raised on the edge that brings cnt to 0.
          if (cnt == '0) begin
            ser_active <= 1'b0;
            if (GAP > 0) begin
              state <= S_GAP;
              gcnt  <= GAP_LAST;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt  <= cnt - 1'b1;
            done <= (cnt == CW'(1));
          end
        end
        S_GAP: begin
          if (gcnt == '0) state <= S_IDLE;
          else            gcnt  <= gcnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_rr_scheduler.sv
// Directed bench for serializer_rr_scheduler with a grant scoreboard and round-robin model.
module tb_serializer_rr_scheduler;
  localparam int N = 4;
  localparam int W = 6;
  localparam int GAP = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   ack;
  logic           ser_load;
  logic [W-1:0]   ser_data;
  logic           ser_active;
  logic [1:0]     grant_id;
  logic           done;

  serializer_rr_scheduler #(.N(N), .W(W), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .ack(ack),
    .ser_load(ser_load), .ser_data(ser_data), .ser_active(ser_active),
    .grant_id(grant_id), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_load = 0;
  int model_last = N - 1;

  typedef struct {
    int           id;
    logic [W-1:0] word;
  } exp_t;
  exp_t sb[$];

  logic [W-1:0] words [N] = '{6'b001010, 6'b101101, 6'b110011, 6'b011100};

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first set bit after model_last, wrapping.
  task automatic predict(input logic [N-1:0] r);
    exp_t e;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (model_last + k) % N;
      if (r[i]) begin
        model_last = i;
        e.id = i;
        e.word = words[i];
        sb.push_back(e);
        return;
      end
    end
  endtask

  exp_t cur;

  task automatic load_check(input string tag, input bit check_period);
    int t;
    t = 0;
    while (!ser_load && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_load_seen"}, 32'(ser_load), 32'd1);
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) cur = sb.pop_front();
    check({tag, "_ack"}, 32'(ack), 32'(4'b0001 << cur.id));
    check({tag, "_grant_id"}, 32'(grant_id), 32'(cur.id));
    check({tag, "_ser_data"}, 32'(ser_data), 32'(cur.word));
    check({tag, "_active_at_load"}, 32'(ser_active), 32'd0);
    if (check_period) check({tag, "_period"}, 32'(cyc - last_load), 32'd9);
    last_load = cyc;
  endtask

  task automatic shift_check(input string tag, input bit drop_mid);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (drop_mid && i == 1) req = 4'b1000;
      if (drop_mid && i == 3) req = 4'b0000;
      check({tag, "_active"}, 32'(ser_active), 32'd1);
      check({tag, "_done"}, 32'(done), 32'(i == W - 1));
      check({tag, "_strobes"}, 32'({ack, ser_load}), 32'd0);
    end
    @(negedge clk);
    check({tag, "_gap"}, 32'({ser_active, done, ser_load, ack}), 32'd0);
    check({tag, "_data_hold"}, 32'(ser_data), 32'(cur.word));
    check({tag, "_gid_hold"}, 32'(grant_id), 32'(cur.id));
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) data_in[i*W +: W] = words[i];
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: idle with no requests
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", 32'({ack, ser_load, ser_data, ser_active, grant_id, done}), 32'd0);
    end

    // 2: single request from requester 1
    req = 4'b0010;
    predict(req);
    load_check("t2", 1'b0);
    req = '0;
    shift_check("t2", 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("t2_no_regrant", 32'({ack, ser_load}), 32'd0);
    end

    // 3: all requesting, fresh round-robin pointer
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last = N - 1;
    req = 4'b1111;
    for (int i = 0; i < 7; i++) predict(req);
    for (int i = 0; i < 7; i++) begin
      load_check("t3", i > 0);
      shift_check("t3", 1'b0);
    end

    // 4: after grant to 2, requests 0 and 2 -> wrap to 0 then 2
    req = 4'b0101;
    predict(req);
    predict(req);
    load_check("t4a", 1'b1);
    shift_check("t4a", 1'b0);
    load_check("t4b", 1'b1);
    req = '0;
    shift_check("t4b", 1'b0);

    // 5: requester 3 asserts and withdraws while 1 owns the shifter
    req = 4'b0010;
    predict(req);
    load_check("t5", 1'b0);
    shift_check("t5", 1'b1);
    repeat (20) begin
      @(negedge clk);
      check("t5_no_ack", 32'({ack, ser_load}), 32'd0);
    end
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // 6: reset in shift cycle 3 aborts the frame
    req = 4'b0001;
    predict(req);
    load_check("t6a", 1'b0);
    req = '0;
    repeat (3) @(negedge clk);
    check("t6_mid_active", 32'(ser_active), 32'd1);
    #1 rst = 1'b1;
    #1 check("t6_async_clear", 32'({ack, ser_load, ser_data, ser_active, grant_id, done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_last = N - 1;
    repeat (8) begin
      @(negedge clk);
      check("t6_no_done", 32'({done, ser_active}), 32'd0);
    end
    req = 4'b0100;
    predict(req);
    load_check("t6b", 1'b0);
    req = '0;
    shift_check("t6b", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
